// File: rtl/arb_pkg.sv
// Shared types and helpers for the burst-locking arbiter front end.
//   state_t        : lock FSM states (IDLE presents requests, LOCKED streams one burst).
//   beat_t         : {data, src, last} beat layout at the default widths.
//   lowest_onehot  : isolates the lowest set bit of a request/grant vector.
//   onehot_to_idx  : binary index of a one-hot vector.
// Helpers work on MAX_REQ-wide vectors; callers zero-extend and size-cast the results.
package arb_pkg;

    localparam int unsigned MAX_REQ     = 32;
    localparam int unsigned IDX_W       = $clog2(MAX_REQ);
    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned SRC_W_DEF   = $clog2(NUM_REQ_DEF);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [SRC_W_DEF-1:0]  src;
        logic                  last;
    } beat_t;

    // Two's-complement trick: vec & -vec keeps only the lowest set bit.
    function automatic logic [MAX_REQ-1:0] lowest_onehot(input logic [MAX_REQ-1:0] vec);
        return vec & (~vec + MAX_REQ'(1));
    endfunction

    // OR-reduction of indices; exact for one-hot input, zero for an all-zero vector.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (vec[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry FIFO register stage with a valid/ready output side.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_push       : write i_data this cycle (ignored while full)
//   i_data       : entry to write
//   i_pop_ready  : downstream accepts the head entry
//   o_data       : head entry (output is valid while o_count != 0)
//   o_full       : both entries occupied
//   o_count      : number of entries held (0..2)
module skid_buf2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != 2'd2);
    assign w_pop   = (r_count != 2'd0) && i_pop_ready;
    assign o_data  = r_head;
    assign o_full  = (r_count == 2'd2);
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head  <= i_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    // Push and pop together: new entry replaces the departing head.
                    if (w_push && w_pop) begin
                        r_head <= i_data;
                    end else if (w_push) begin
                        r_tail  <= i_data;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_count <= 2'd1;
                    end
                end
                default: r_count <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/arb_burst_mux.sv
// Burst-locking front end for an external fixed-priority arbiter.
// Presents requests to the arbiter while idle, locks onto the granted requester until its
// last beat, and funnels the winner's beats through a 2-entry skid buffer.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   i_req_valid/data/last       : per-requester beat channel (data packed DATA_W per requester)
//   o_req_ready                 : per-requester accept, at most one bit set
//   o_arb_req, i_arb_grant      : request/grant pair to the external arbiter
//   o_out_valid/data/src/last   : output beat channel, i_out_ready is downstream accept
module arb_burst_mux
    import arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned DATA_W  = 32,
    localparam int unsigned SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]        i_req_last,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [NUM_REQ-1:0]        o_arb_req,
    input  logic [NUM_REQ-1:0]        i_arb_grant,
    output logic                      o_out_valid,
    output logic [DATA_W-1:0]         o_out_data,
    output logic [SRC_W-1:0]          o_out_src,
    output logic                      o_out_last,
    input  logic                      i_out_ready
);

    localparam int unsigned BEAT_W = DATA_W + SRC_W + 1;

    state_t               r_state;
    state_t               w_state_d;
    logic [NUM_REQ-1:0]   r_lock_oh;
    logic [NUM_REQ-1:0]   w_lock_oh_d;
    logic [SRC_W-1:0]     r_lock_idx;
    logic [SRC_W-1:0]     w_lock_idx_d;

    logic [MAX_REQ-1:0]   w_pick_wide;
    logic [DATA_W-1:0]    w_sel_data;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic                 w_full;
    logic [1:0]           w_count;
    logic                 w_xfer;
    logic [BEAT_W-1:0]    w_head;

    // Grants to non-requesting ports are masked; a non-one-hot grant resolves to its lowest bit.
    assign w_pick_wide = lowest_onehot(MAX_REQ'(i_arb_grant & i_req_valid));

    // Locked requester's channel, selected by the registered one-hot lock.
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_lock_oh[i]) begin
                w_sel_data  = i_req_data[i*DATA_W +: DATA_W];
                w_sel_valid = i_req_valid[i];
                w_sel_last  = i_req_last[i];
            end
        end
    end

    assign w_xfer = (r_state == LOCKED) && w_sel_valid && !w_full;

    always_comb begin
        w_state_d    = r_state;
        w_lock_oh_d  = r_lock_oh;
        w_lock_idx_d = r_lock_idx;
        o_arb_req    = '0;
        o_req_ready  = '0;
        case (r_state)
            IDLE: begin
                o_arb_req = i_req_valid;
                if (|w_pick_wide) begin
                    w_lock_oh_d  = NUM_REQ'(w_pick_wide);
                    w_lock_idx_d = SRC_W'(onehot_to_idx(w_pick_wide));
                    w_state_d    = LOCKED;
                end
            end
            LOCKED: begin
                // Depends on registered state only, never on i_out_ready.
                if (!w_full) begin
                    o_req_ready = r_lock_oh;
                end
                if (w_xfer && w_sel_last) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_lock_oh  <= '0;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_d;
            r_lock_oh  <= w_lock_oh_d;
            r_lock_idx <= w_lock_idx_d;
        end
    end

    skid_buf2 #(
        .WIDTH (BEAT_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_xfer),
        .i_data      ({w_sel_data, r_lock_idx, w_sel_last}),
        .i_pop_ready (i_out_ready),
        .o_data      (w_head),
        .o_full      (w_full),
        .o_count     (w_count)
    );

    assign o_out_valid = (w_count != 2'd0);
    assign {o_out_data, o_out_src, o_out_last} = w_head;

endmodule

// File: tb/tb_arb_burst_mux.sv
// Directed bench for arb_burst_mux with an external fixed-priority arbiter model, per-requester
// burst queues, and an expected-beat scoreboard checked on every output handshake.
module tb_arb_burst_mux;
    import arb_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NR-1:0]  req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  req_last;
    logic [NR-1:0]  req_ready;
    logic [NR-1:0]  arb_req;
    logic [NR-1:0]  arb_grant;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic [SW-1:0]  out_src;
    logic           out_last;
    logic           out_ready;

    logic           force_grant_en;
    logic [NR-1:0]  force_grant;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [DW:0] src_q [NR][$];   // {last, data} per requester
    beat_t       exp_q[$];

    logic [NR-1:0] rdy_h [1024];
    logic [NR-1:0] acc_h [1024];
    logic [NR-1:0] arb_h [1024];
    logic          vld_h [1024];
    logic [DW-1:0] dat_h [1024];

    always #5 clk = ~clk;

    arb_burst_mux #(
        .NUM_REQ (NR),
        .DATA_W  (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_arb_req   (arb_req),
        .i_arb_grant (arb_grant),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .o_out_src   (out_src),
        .o_out_last  (out_last),
        .i_out_ready (out_ready)
    );

    // External fixed-priority arbiter (req 0 highest), overridable for bad-grant cases.
    always_comb arb_grant = force_grant_en ? force_grant : (arb_req & (~arb_req + 4'd1));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic load(input int r, input logic [DW-1:0] base, input int n);
        for (int k = 0; k < n; k++) src_q[r].push_back({k == n - 1, base + DW'(k)});
    endtask

    task automatic expect_burst(input int r, input logic [DW-1:0] base, input int n);
        beat_t e;
        for (int k = 0; k < n; k++) begin
            e.data = base + DW'(k);
            e.src  = SW'(r);
            e.last = (k == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]             = 1'b1;
                req_data[i*DW +: DW]     = src_q[i][0][DW-1:0];
                req_last[i]              = src_q[i][0][DW];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    // One clock: log at the falling edge, retire accepted beats just after the rising edge.
    task automatic tick();
        logic [NR-1:0] acc;
        @(negedge clk);
        acc        = req_valid & req_ready;
        rdy_h[cyc] = req_ready;
        acc_h[cyc] = acc;
        arb_h[cyc] = arb_req;
        vld_h[cyc] = out_valid;
        dat_h[cyc] = out_data;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (acc[i]) void'(src_q[i].pop_front());
        cyc++;
        drive();
    endtask

    function automatic bit pending();
        bit p;
        p = (exp_q.size() != 0) || out_valid;
        for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while (pending() && n < 40) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        check({name, "_idle"}, 64'(pending()), 64'd0);
    endtask

    // Scoreboard: every accepted output beat must be the next expected one.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("req_ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_beat: got data 0x%0h src %0d, want no beat",
                                 out_data, out_src);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 64'(out_data), 64'(e.data));
                        check("out_src", 64'(out_src), 64'(e.src));
                        check("out_last", 64'(out_last), 64'(e.last));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int sum;
        logic [6:0] vpat;
        req_valid      = '0;
        req_last       = '0;
        req_data       = '0;
        out_ready      = 1'b1;
        force_grant_en = 1'b1;
        force_grant    = '0;

        // Reset values; arb_req follows req_valid while held in reset.
        req_valid = 4'b0101;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_src", 64'(out_src), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_arb_req", 64'(arb_req), 64'h5);
        req_valid      = '0;
        force_grant_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive();

        // Single 3-beat burst from req 2.
        load(2, 32'hA0, 3);
        expect_burst(2, 32'hA0, 3);
        drive();
        st = cyc;
        repeat (7) tick();
        vpat = 7'b0011100;
        for (int k = 0; k < 7; k++) check("t1_out_valid", 64'(vld_h[st+k]), 64'(vpat[k]));
        check("t1_ready_c1", 64'(rdy_h[st+1]), 64'h4);
        check("t1_ready_c4", 64'(rdy_h[st+4]), 64'h0);
        check("t1_first_data", 64'(dat_h[st+2]), 64'hA0);
        drain("t1_drain");

        // Req 3 locked while req 0 arrives mid-burst.
        load(3, 32'h30, 4);
        expect_burst(3, 32'h30, 4);
        expect_burst(0, 32'h10, 2);
        drive();
        st = cyc;
        tick();
        tick();
        load(0, 32'h10, 2);
        drive();
        repeat (8) tick();
        check("t2_arb_locked", 64'(arb_h[st+3]), 64'h0);
        check("t2_ready_locked", 64'(rdy_h[st+3]), 64'h8);
        check("t2_last_xfer", 64'(acc_h[st+4]), 64'h8);
        check("t2_bubble", 64'(acc_h[st+5]), 64'h0);
        check("t2_rearb_req", 64'(arb_h[st+5]), 64'h1);
        check("t2_next_first", 64'(acc_h[st+6]), 64'h1);
        drain("t2_drain");

        // Backpressure on a 4-beat burst from req 1.
        out_ready = 1'b0;
        load(1, 32'h40, 4);
        expect_burst(1, 32'h40, 4);
        drive();
        st = cyc;
        repeat (6) tick();
        check("t3_ready_c1", 64'(rdy_h[st+1]), 64'h2);
        check("t3_ready_c2", 64'(rdy_h[st+2]), 64'h2);
        check("t3_ready_full", 64'(rdy_h[st+3]), 64'h0);
        check("t3_ready_held", 64'(rdy_h[st+5]), 64'h0);
        sum = 0;
        for (int k = 0; k < 6; k++) sum += int'(acc_h[st+k][1]);
        check("t3_buffered", 64'(sum), 64'd2);
        check("t3_head_valid", 64'(vld_h[st+5]), 64'd1);
        check("t3_head_data", 64'(dat_h[st+5]), 64'h40);
        out_ready = 1'b1;
        drain("t3_drain");

        // Non-one-hot grant resolves to the lowest valid bit.
        force_grant_en = 1'b1;
        force_grant    = 4'b0110;
        load(1, 32'h60, 1);
        load(2, 32'h70, 1);
        expect_burst(1, 32'h60, 1);
        expect_burst(2, 32'h70, 1);
        drive();
        st = cyc;
        repeat (6) tick();
        check("t4_lock_req1", 64'(acc_h[st+1]), 64'h2);
        check("t4_then_req2", 64'(acc_h[st+3]), 64'h4);
        drain("t4_drain");

        // Grant to a non-requesting port is ignored.
        force_grant = 4'b1000;
        load(0, 32'h80, 1);
        drive();
        st = cyc;
        repeat (4) tick();
        check("t4b_ready_c1", 64'(rdy_h[st+1]), 64'h0);
        check("t4b_ready_c3", 64'(rdy_h[st+3]), 64'h0);
        check("t4b_no_xfer", 64'(acc_h[st+3]), 64'h0);
        check("t4b_still_idle", 64'(arb_h[st+2]), 64'h1);
        expect_burst(0, 32'h80, 1);
        force_grant_en = 1'b0;
        drain("t4b_drain");

        // Reset while one beat is buffered.
        out_ready = 1'b0;
        load(2, 32'h50, 3);
        expect_burst(2, 32'h50, 3);
        drive();
        tick();
        tick();
        check("t5_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_ready", 64'(req_ready), 64'h0);
        check("t5_rst_arb", 64'(arb_req), 64'h4);
        exp_q.delete();
        expect_burst(2, 32'h51, 2);
        tick();
        tick();
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drain("t5_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
